// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline-control types: controller FSM states and PC source encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package CPU_Defines;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DIV   = 2'd1,
    REDIR = 2'd2
  } CtrlState_t;

  localparam logic [1:0] PCSEL_SEQ    = 2'd0;
  localparam logic [1:0] PCSEL_BRANCH = 2'd1;
  localparam logic [1:0] PCSEL_EXC    = 2'd2;
  localparam logic [1:0] PCSEL_EPC    = 2'd3;

  // Exception outranks ERET when both sit in MEM together.
  function automatic logic [1:0] exc_target(input logic exc_valid);
    return exc_valid ? PCSEL_EXC : PCSEL_EPC;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_stall_perf_cnt.sv
// Saturating 32-bit event counter with enable and synchronous clear.
// Latency: count updates on the clock edge after i_en; clear wins over enable.
// Backpressure: none; holds at all-ones once saturated.
// Ports: clk, i_clr (sync clear), i_en (count this cycle), o_count.
module stall_perf_cnt (
  input  logic        clk,
  input  logic        i_clr,
  input  logic        i_en,
  output logic [31:0] o_count
);

  logic [31:0] r_count;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != 32'hFFFF_FFFF)) begin
      r_count <= r_count + 32'd1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush/redirect sequencer driving every pipeline register's write-enable and flush.
// Latency: all control outputs are combinational from state and inputs (zero cycles).
// Backpressure: ICache/DCache busy, divide and load-use stall the pipe by dropping write-enables.
// Ports: clk/rst; hazard inputs (cache busy, div, load-use, branch, exception/ERET);
//        per-stage *_Wr/*_Flush, PC_Sel, Div_Start, Ctrl_State, Stall_Cycles.
module pipeline_ctrl
  import CPU_Defines::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ICache_Busy,
  input  logic        DCache_Busy,
  input  logic        EX_IsDiv,
  input  logic        Div_Done,
  input  logic        ID_LoadUse,
  input  logic        EX_BranchTaken,
  input  logic        MEM_ExcValid,
  input  logic        MEM_IsEret,
  output logic        PC_Wr,
  output logic        ID_Wr,
  output logic        EX_Wr,
  output logic        MEM_Wr,
  output logic        WB_Wr,
  output logic        ID_Flush,
  output logic        EX_Flush,
  output logic        MEM_Flush,
  output logic        WB_Flush,
  output logic [1:0]  PC_Sel,
  output logic        Div_Start,
  output logic [1:0]  Ctrl_State,
  output logic [31:0] Stall_Cycles
);

  CtrlState_t r_state;
  CtrlState_t w_state_nxt;
  logic [1:0] r_redir_sel;
  logic [1:0] w_redir_nxt;
  logic       w_exc_evt;
  logic [1:0] w_exc_tgt;

  assign w_exc_evt = MEM_ExcValid | MEM_IsEret;
  assign w_exc_tgt = exc_target(MEM_ExcValid);

  always_comb begin
    PC_Wr       = 1'b1;
    ID_Wr       = 1'b1;
    EX_Wr       = 1'b1;
    MEM_Wr      = 1'b1;
    WB_Wr       = 1'b1;
    ID_Flush    = 1'b0;
    EX_Flush    = 1'b0;
    MEM_Flush   = 1'b0;
    WB_Flush    = 1'b0;
    PC_Sel      = PCSEL_SEQ;
    Div_Start   = 1'b0;
    w_state_nxt = r_state;
    w_redir_nxt = r_redir_sel;

    if (rst) begin
      PC_Wr     = 1'b0;
      ID_Wr     = 1'b0;
      EX_Wr     = 1'b0;
      MEM_Wr    = 1'b0;
      WB_Wr     = 1'b0;
      ID_Flush  = 1'b1;
      EX_Flush  = 1'b1;
      MEM_Flush = 1'b1;
      WB_Flush  = 1'b1;
    end else begin
      unique case (r_state)
        RUN: begin
          if (w_exc_evt) begin
            // The faulting instruction retires in WB with its own suppressed write.
            ID_Flush  = 1'b1;
            EX_Flush  = 1'b1;
            MEM_Flush = 1'b1;
            if (!ICache_Busy) begin
              PC_Sel = w_exc_tgt;
            end else begin
              PC_Wr       = 1'b0;
              w_redir_nxt = w_exc_tgt;
              w_state_nxt = REDIR;
            end
          end else if (DCache_Busy) begin
            // Whole pipe freezes; branch/div are re-seen once the freeze lifts.
            PC_Wr    = 1'b0;
            ID_Wr    = 1'b0;
            EX_Wr    = 1'b0;
            MEM_Wr   = 1'b0;
            WB_Flush = 1'b1;
          end else if (EX_IsDiv) begin
            Div_Start   = 1'b1;
            PC_Wr       = 1'b0;
            ID_Wr       = 1'b0;
            EX_Wr       = 1'b0;
            MEM_Flush   = 1'b1;
            w_state_nxt = DIV;
          end else if (EX_BranchTaken) begin
            // Drops the wrong-path fetch; the delay slot in ID still moves on.
            ID_Flush = 1'b1;
            if (!ICache_Busy) begin
              PC_Sel = PCSEL_BRANCH;
            end else begin
              PC_Wr       = 1'b0;
              w_redir_nxt = PCSEL_BRANCH;
              w_state_nxt = REDIR;
            end
            if (ID_LoadUse) begin
              ID_Wr    = 1'b0;
              EX_Flush = 1'b1;
            end
          end else if (ID_LoadUse) begin
            PC_Wr    = 1'b0;
            ID_Wr    = 1'b0;
            EX_Flush = 1'b1;
          end else if (ICache_Busy) begin
            PC_Wr    = 1'b0;
            ID_Flush = 1'b1;
          end
        end

        DIV: begin
          if (!Div_Done) begin
            PC_Wr     = 1'b0;
            ID_Wr     = 1'b0;
            EX_Wr     = 1'b0;
            MEM_Flush = 1'b1;
          end else begin
            // MEM captures the divide result on this edge.
            w_state_nxt = RUN;
            if (ICache_Busy) begin
              PC_Wr    = 1'b0;
              ID_Flush = 1'b1;
            end
          end
        end

        REDIR: begin
          ID_Flush = 1'b1;
          if (w_exc_evt) begin
            // A newer exception/ERET replaces the pending redirect target.
            EX_Flush    = 1'b1;
            MEM_Flush   = 1'b1;
            w_redir_nxt = w_exc_tgt;
          end else if (DCache_Busy) begin
            EX_Wr    = 1'b0;
            MEM_Wr   = 1'b0;
            WB_Flush = 1'b1;
          end
          if (ICache_Busy) begin
            PC_Wr = 1'b0;
          end else begin
            PC_Sel      = w_exc_evt ? w_exc_tgt : r_redir_sel;
            w_state_nxt = RUN;
          end
        end

        default: begin
          w_state_nxt = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= RUN;
      r_redir_sel <= PCSEL_SEQ;
    end else begin
      r_state     <= w_state_nxt;
      r_redir_sel <= w_redir_nxt;
    end
  end

  assign Ctrl_State = r_state;

  stall_perf_cnt u_stall_cnt (
    .clk     (clk),
    .i_clr   (rst),
    .i_en    (~PC_Wr),
    .o_count (Stall_Cycles)
  );

endmodule
